// File: rtl/shift_pkg.sv
// Shared types for the shift command path.
//   shift_dir_e : shift direction (left = 0, right = 1)
//   shift_cmd_t : one queued command {data, amt, dir}, 12 bits packed
package shift_pkg;

    localparam int SHIFT_W     = 8;
    localparam int SHIFT_AMT_W = 3;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    typedef struct packed {
        logic [SHIFT_W-1:0]     data;
        logic [SHIFT_AMT_W-1:0] amt;
        shift_dir_e             dir;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Command storage: DEPTH x shift_cmd_t circular buffer.
//   clk, rst_n    : clock, synchronous active-low reset
//   clr           : synchronous clear (pointers back to 0)
//   push, wdata   : write one entry (caller guarantees !full)
//   pop           : retire the head entry (caller guarantees !empty)
//   rdata         : current head entry
//   full, empty   : occupancy flags
//   level         : occupancy, only with SHIFT_CMD_QUEUE_LEVEL_EN defined
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  shift_cmd_t               wdata,
    input  logic                     pop,
    output shift_cmd_t               rdata,
    output logic                     full,
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    output logic [$clog2(DEPTH):0]   level,
`endif
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    shift_cmd_t     mem [DEPTH];
    // One extra MSB on each pointer separates full (MSBs differ) from empty.
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: rtl/shift_cmd_queue.sv
// Shift command queue: buffers shift commands, presents the head to an
// external combinational shifter and registers its result.
//   clk, rst_n             : clock, synchronous active-low reset
//   flush                  : clears queue and result stage, overrides handshakes
//   cmd_valid/ready/data/amt/dir : command input handshake
//   sh_data_in/shift_amt/dir     : head command to the shifter (0 when empty)
//   sh_data_out            : shifter result for the head command
//   res_valid/ready/data   : registered result handshake
//   level                  : occupancy, only with SHIFT_CMD_QUEUE_LEVEL_EN defined
module shift_cmd_queue
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [W-1:0]             cmd_data,
    input  logic [2:0]               cmd_amt,
    input  logic                     cmd_dir,
    output logic [W-1:0]             sh_data_in,
    output logic [2:0]               sh_shift_amt,
    output logic                     sh_dir,
    input  logic [W-1:0]             sh_data_out,
    output logic                     res_valid,
    input  logic                     res_ready,
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    output logic [$clog2(DEPTH):0]   level,
`endif
    output logic [W-1:0]             res_data
);

    shift_cmd_t wcmd;
    shift_cmd_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign cmd_ready = !fifo_full && !flush;
    assign push      = cmd_valid && cmd_ready;
    // Empty is registered, so a command pushed this cycle cannot pop until the next.
    assign pop       = !fifo_empty && (!res_valid || res_ready) && !flush;

    assign wcmd = '{data: cmd_data, amt: cmd_amt, dir: shift_dir_e'(cmd_dir)};

    shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        .level (level),
`endif
        .empty (fifo_empty)
    );

    assign sh_data_in   = fifo_empty ? '0   : head.data;
    assign sh_shift_amt = fifo_empty ? '0   : head.amt;
    assign sh_dir       = fifo_empty ? 1'b0 : head.dir;

    // Result stage: a pop both frees a held result and loads the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (pop) begin
            res_valid <= 1'b1;
            res_data  <= sh_data_out;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_cmd_queue.sv
module tb_shift_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, flush, cmd_valid, cmd_ready, cmd_dir;
    logic [7:0] cmd_data, sh_data_in, sh_data_out, res_data;
    logic [2:0] cmd_amt, sh_shift_amt;
    logic       sh_dir, res_valid, res_ready;
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_cmd_queue #(.DEPTH(DEPTH), .W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_amt      (cmd_amt),
        .cmd_dir      (cmd_dir),
        .sh_data_in   (sh_data_in),
        .sh_shift_amt (sh_shift_amt),
        .sh_dir       (sh_dir),
        .sh_data_out  (sh_data_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        .level        (level),
`endif
        .res_data     (res_data)
    );

    // External shifter the queue drives.
    assign sh_data_out = sh_dir ? (sh_data_in >> sh_shift_amt) : (sh_data_in << sh_shift_amt);

    // Reference: shift expressed as multiply/divide by a power of two.
    function automatic logic [7:0] shf(input logic [11:0] c);
        int v, p;
        v = int'(c[11:4]);
        p = 1 << int'(c[3:1]);
        return c[0] ? 8'(v / p) : 8'((v * p) % 256);
    endfunction

    // Behavioural model: a queue of accepted commands plus a held result.
    logic [11:0] mq[$];
    logic        m_rv = 1'b0;
    logic [7:0]  m_rd = 8'h00;

    task automatic mdl_step();
        logic do_pop, do_push;
        if (!rst_n) begin
            mq.delete(); m_rv = 1'b0; m_rd = 8'h00;
        end else if (flush) begin
            mq.delete(); m_rv = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && (!m_rv || res_ready);
            do_push = cmd_valid && (mq.size() < DEPTH);
            if (do_pop) begin
                m_rd = shf(mq.pop_front());
                m_rv = 1'b1;
            end else if (res_ready) begin
                m_rv = 1'b0;
            end
            if (do_push) mq.push_back({cmd_data, cmd_amt, cmd_dir});
        end
    endtask

    // Inputs change only at negedge; the model samples them just before the posedge.
    task automatic cyc();
        mdl_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] a, input logic dir);
        cmd_valid = 1'b1; cmd_data = d; cmd_amt = a; cmd_dir = dir;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b exp 0", res_valid); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h exp 00", res_data); end
        checks++; if ({sh_data_in, sh_shift_amt, sh_dir} !== 12'h000) begin errors++;
            $display("FAIL reset_sh: got %h/%0d/%b exp 0", sh_data_in, sh_shift_amt, sh_dir); end
        rst_n = 1'b1;
        cyc();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", cmd_ready); end
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
`endif
    endtask

    task automatic test_single();
        drive(8'h81, 3'd1, 1'b0);
        res_ready = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", cmd_ready); end
        cyc();
        cmd_valid = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_bypass: got rv %b exp 0", res_valid); end
        checks++; if (sh_data_in !== 8'h81) begin errors++; $display("FAIL single_head: got %h exp 81", sh_data_in); end
        cyc();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h02) begin errors++;
            $display("FAIL single_res: got rv %b rd %h exp 1/02", res_valid, res_data); end
        cyc();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got rv %b exp 0", res_valid); end
    endtask

    task automatic test_order();
        logic [7:0] exp_rd [3];
        exp_rd[0] = 8'h0F; exp_rd[1] = 8'hF0; exp_rd[2] = 8'hAA;
        res_ready = 1'b1;
        drive(8'hF0, 3'd4, 1'b1); cyc();
        drive(8'h0F, 3'd4, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(8'hAA, 3'd0, 1'b0); else cmd_valid = 1'b0;
            #1;
            checks++; if (res_valid !== 1'b1 || res_data !== exp_rd[i]) begin errors++;
                $display("FAIL order_%0d: got rv %b rd %h exp 1/%h", i, res_valid, res_data, exp_rd[i]); end
            cyc();
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL order_end: got rv %b exp 0", res_valid); end
    endtask

    task automatic test_full();
        logic [7:0]  ex [5];
        logic [11:0] c;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = {8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            ex[i] = shf(c);
            drive(c[11:4], c[3:1], c[0]);
            #1;
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_acc_%0d: got ready %b exp 1", i, cmd_ready); end
            cyc();
        end
        drive(8'h55, 3'd1, 1'b0);
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", cmd_ready); end
        checks++; if (res_valid !== 1'b1 || res_data !== ex[0]) begin errors++;
            $display("FAIL full_held: got rv %b rd %h exp 1/%h", res_valid, res_data, ex[0]); end
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checks++; if (level !== 4) begin errors++; $display("FAIL full_level: got %0d exp 4", level); end
`endif
        cyc();
        checks++; if (res_data !== ex[0]) begin errors++; $display("FAIL full_stable: got %h exp %h", res_data, ex[0]); end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            cyc();
            checks++; if (res_valid !== 1'b1 || res_data !== ex[i]) begin errors++;
                $display("FAIL full_drain_%0d: got rv %b rd %h exp 1/%h", i, res_valid, res_data, ex[i]); end
        end
        cyc();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL full_no_extra: got rv %b exp 0", res_valid); end
    endtask

    task automatic test_simul();
        res_ready = 1'b0;
        drive(8'h11, 3'd1, 1'b0); cyc();
        drive(8'h40, 3'd2, 1'b1); cyc();
        drive(8'h03, 3'd3, 1'b0); cyc();
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checks++; if (level !== 2) begin errors++; $display("FAIL simul_pre_level: got %0d exp 2", level); end
`endif
        drive(8'h80, 3'd7, 1'b1);
        res_ready = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h10) begin errors++;
            $display("FAIL simul_res: got rv %b rd %h exp 1/10", res_valid, res_data); end
        checks++; if (sh_data_in !== 8'h03) begin errors++; $display("FAIL simul_head: got %h exp 03", sh_data_in); end
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checks++; if (level !== 2) begin errors++; $display("FAIL simul_level: got %0d exp 2", level); end
`endif
        cyc();
        checks++; if (res_data !== 8'h18) begin errors++; $display("FAIL simul_d1: got %h exp 18", res_data); end
        cyc();
        checks++; if (res_data !== 8'h01) begin errors++; $display("FAIL simul_d2: got %h exp 01", res_data); end
        cyc();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL simul_end: got rv %b exp 0", res_valid); end
    endtask

    task automatic test_flush();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cyc();
        end
        drive(8'h77, 3'd2, 1'b0);
        flush = 1'b1;
        res_ready = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", cmd_ready); end
        cyc();
        flush = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_rv: got %b exp 0", res_valid); end
        checks++; if (sh_data_in !== 8'h00 || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL flush_empty: got sh %h ready %b exp 00/1", sh_data_in, cmd_ready); end
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checks++; if (level !== 0) begin errors++; $display("FAIL flush_level: got %0d exp 0", level); end
`endif
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_%0d: got rv %b exp 0", i, res_valid); end
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'($urandom | 1), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cyc();
        end
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin errors++;
            $display("FAIL rmid_res: got rv %b rd %h exp 0/00", res_valid, res_data); end
        checks++; if (sh_data_in !== 8'h00 || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL rmid_q: got sh %h ready %b exp 00/1", sh_data_in, cmd_ready); end
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_%0d: got rv %b exp 0", i, res_valid); end
        end
    endtask

    task automatic test_random();
        logic       exp_ready;
        logic [7:0] exp_sh;
        for (int n = 0; n < 400; n++) begin
            drive(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cmd_valid = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            exp_ready = (mq.size() < DEPTH) && !flush;
            exp_sh    = (mq.size() > 0) ? mq[0][11:4] : 8'h00;
            checks++; if (cmd_ready !== exp_ready) begin errors++;
                $display("FAIL rand_ready@%0d: got %b exp %b", n, cmd_ready, exp_ready); end
            checks++; if (sh_data_in !== exp_sh) begin errors++;
                $display("FAIL rand_head@%0d: got %h exp %h", n, sh_data_in, exp_sh); end
            checks++; if (res_valid !== m_rv || (m_rv && res_data !== m_rd)) begin errors++;
                $display("FAIL rand_res@%0d: got rv %b rd %h exp %b/%h", n, res_valid, res_data, m_rv, m_rd); end
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
            checks++; if (int'(level) != mq.size()) begin errors++;
                $display("FAIL rand_level@%0d: got %0d exp %0d", n, level, mq.size()); end
`endif
            cyc();
        end
        flush = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
        cmd_data = 8'h00; cmd_amt = 3'd0; cmd_dir = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_order();
        test_full();
        test_simul();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_cmd_queue.md
SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter W, default 8, meaning data width; fixed at 8 to match the shifter datapath.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 flush  in  1  synchronous clear of queue and result stage.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_data  in  8  operand.
REQ-009 cmd_amt  in  3  shift amount, 0-7.
REQ-010 cmd_dir  in  1  0 = left, 1 = right.
REQ-011 sh_data_in  out  8  head operand driven to the shifter.
REQ-012 sh_shift_amt  out  3  head amount driven to the shifter.
REQ-013 sh_dir  out  1  head direction driven to the shifter.
REQ-014 sh_data_out  in  8  combinational shifter result for the head command.
REQ-015 res_valid  out  1  result held.
REQ-016 res_ready  in  1  consumer accepts result when res_valid && res_ready.
REQ-017 res_data  out  8  registered shifted result.

Function
REQ-018 cmd_ready SHALL equal !full && !flush; a push SHALL occur only on cmd_valid && cmd_ready.
REQ-019 Queue SHALL be FIFO-ordered; results SHALL emerge in acceptance order with no loss or duplication.
REQ-020 While non-empty, sh_* SHALL carry the head entry; while empty, sh_data_in, sh_shift_amt, sh_dir SHALL be 0.
REQ-021 Pop SHALL occur when non-empty && (!res_valid || res_ready) && !flush; on pop res_data SHALL load sh_data_out and res_valid SHALL set.
REQ-022 res_valid SHALL clear on res_valid && res_ready with no pop in that cycle.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged; push into empty queue SHALL NOT pop that same cycle (no bypass).
REQ-024 Latency: command accepted at edge N with empty queue and free result stage SHALL give res_valid=1 after edge N+1.
REQ-025 Throughput SHALL be one result per cycle while res_ready=1 and queue non-empty.
REQ-026 Full: cmd_ready=0 while occupancy=DEPTH; read/write pointers SHALL wrap modulo DEPTH, with an extra pointer bit distinguishing full from empty.
REQ-027 res_data SHALL remain stable while res_valid=1 && res_ready=0.
REQ-028 flush=1 SHALL empty the queue, clear res_valid, and override any same-cycle push, pop, or result handshake.

Reset
REQ-029 On rst_n=0 at a clock edge: occupancy 0, pointers 0, res_valid=0, res_data=0; cmd_ready=1 the cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all queued commands and any held result with no further output.

Configuration
REQ-031 Macro SHIFT_CMD_QUEUE_LEVEL_EN defined: output port level, $clog2(DEPTH)+1 bits, equal to current occupancy (0 after reset/flush).
REQ-032 Macro undefined: port level SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package shift_pkg SHALL hold the shift_dir_e enum (SHIFT_LEFT=0, SHIFT_RIGHT=1), the SHIFT_W=8 and SHIFT_AMT_W=3 constants, and the packed shift_cmd_t {data, amt, dir} (12 bits).
REQ-034 Storage SHALL be one sub-module, shift_cmd_fifo (DEPTH x shift_cmd_t, registered pointers, full/empty/level); pop handshake and result register live in the top.

Verification
REQ-035 Single: push {0x81, amt 1, left}, res_ready=1, shifter connected -> res_valid after edge N+1, res_data=0x02.
REQ-036 Order: push 0xF0/4/right, 0x0F/4/left, 0xAA/0/left back-to-back -> res_data 0x0F, 0xF0, 0xAA on consecutive cycles.
REQ-037 Full/backpressure: res_ready=0, push 5 commands at DEPTH=4 -> 1 held in result stage + 4 queued, cmd_ready=0; release res_ready -> all 5 results delivered in order.
REQ-038 Simultaneous push/pop at occupancy 2 with res_ready=1 -> occupancy stays 2, level=2 when SHIFT_CMD_QUEUE_LEVEL_EN defined.
REQ-039 Flush with 3 queued, res_valid=1, cmd_valid=1 same cycle -> next cycle res_valid=0, queue empty, flushed command not accepted.
REQ-040 Reset mid-stream with 2 queued -> outputs per REQ-029, no stale result appears afterwards.
